// File: rtl/palette_pkg.sv
// Shared constants for the palette lookup: the power-on palette and a helper
// that adapts each default entry to the configured colour width.
package palette_pkg;

    localparam int DEFAULT_COUNT = 14;
    localparam int DEFAULT_W     = 9;
    localparam int MAX_COLOR_W   = 32;

    localparam logic [DEFAULT_W-1:0] DEFAULT_PALETTE [DEFAULT_COUNT] = '{
        9'h000, 9'h00B, 9'h027, 9'h078, 9'h0CF, 9'h124, 9'h1C0,
        9'h1CC, 9'h1E0, 9'h1E4, 9'h1E7, 9'h1F4, 9'h1F8, 9'h1FF
    };

    // Wider colours pad zeros below the RGB333 bits; narrower ones drop LSBs.
    function automatic logic [MAX_COLOR_W-1:0] default_entry(input int idx, input int colorW);
        logic [MAX_COLOR_W-1:0] base;
        base = '0;
        if (idx >= 0 && idx < DEFAULT_COUNT) begin
            base = MAX_COLOR_W'(DEFAULT_PALETTE[idx[3:0]]);
        end
        if (colorW >= DEFAULT_W) begin
            default_entry = base << (colorW - DEFAULT_W);
        end else begin
            default_entry = base >> (DEFAULT_W - colorW);
        end
    endfunction

endpackage

// File: rtl/palette_cycler.sv
// Frame-tick divider for palette colour cycling; emits a one-cycle rotate
// strobe every CYCLE_DIV ticks. A commit clears the divider and suppresses the step.
module palette_cycler
    import palette_pkg::*;
#(
    parameter int CYCLE_DIV = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_frame_tick,
    input  logic i_commit,
    output logic o_rotate
);

    localparam int DIV_W = (CYCLE_DIV > 1) ? $clog2(CYCLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CYCLE_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign o_rotate = i_frame_tick && !i_commit && (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (i_commit) begin
            div_d = '0;
        end else if (i_frame_tick) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/palette_lut.sv
// Double-banked programmable palette: writes land in a shadow bank that is
// copied to the active bank on commit. Define PALETTE_LUT_CYCLE_EN for colour cycling.
module palette_lut
    import palette_pkg::*;
#(
    parameter int INDEX_W   = 4,
    parameter int COLOR_W   = 9,
    parameter int CYCLE_LO  = 2,
    parameter int CYCLE_HI  = 4,
    parameter int CYCLE_DIV = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pix_valid,
    input  logic [INDEX_W-1:0] i_pix_index,
    output logic               o_pix_valid,
    output logic [COLOR_W-1:0] o_color,
    input  logic               i_wr_valid,
    output logic               o_wr_ready,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [COLOR_W-1:0] i_wr_color,
    input  logic               i_commit,
    input  logic               i_frame_tick,
    output logic               o_dirty
);

    localparam int DEPTH = 1 << INDEX_W;

    logic [COLOR_W-1:0] resetPalette [DEPTH];
    logic [COLOR_W-1:0] active_q [DEPTH];
    logic [COLOR_W-1:0] active_d [DEPTH];
    logic [COLOR_W-1:0] shadow_q [DEPTH];
    logic [COLOR_W-1:0] shadow_d [DEPTH];
    logic [COLOR_W-1:0] color_q;
    logic               pixValid_q;
    logic               dirty_q;
    logic               dirty_d;
    logic               wrAccept;

    for (genvar g = 0; g < DEPTH; g++) begin : gen_reset_palette
        localparam logic [MAX_COLOR_W-1:0] ENTRY = default_entry(g, COLOR_W);
        assign resetPalette[g] = ENTRY[COLOR_W-1:0];
    end

    // Writes are refused during a commit so the copy always sees a stable shadow.
    assign o_wr_ready = i_rst_n && !i_commit;
    assign wrAccept   = i_wr_valid && o_wr_ready;

`ifdef PALETTE_LUT_CYCLE_EN
    logic rotateStep;

    palette_cycler #(
        .CYCLE_DIV (CYCLE_DIV)
    ) u_cycler (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_frame_tick (i_frame_tick),
        .i_commit     (i_commit),
        .o_rotate     (rotateStep)
    );
`else
    localparam int unusedCycleCfg = CYCLE_LO + CYCLE_HI + CYCLE_DIV;
    logic unusedFrameTick;
    assign unusedFrameTick = i_frame_tick;
`endif

    always_comb begin
        shadow_d = shadow_q;
        if (wrAccept) begin
            shadow_d[i_wr_index] = i_wr_color;
        end
    end

    always_comb begin
        active_d = active_q;
        if (i_commit) begin
            active_d = shadow_q;
        end
`ifdef PALETTE_LUT_CYCLE_EN
        else if (rotateStep) begin
            for (int k = CYCLE_LO; k < CYCLE_HI; k++) begin
                active_d[k] = active_q[k + 1];
            end
            active_d[CYCLE_HI] = active_q[CYCLE_LO];
        end
`endif
    end

    always_comb begin
        dirty_d = dirty_q;
        if (i_commit) begin
            dirty_d = 1'b0;
        end else if (wrAccept) begin
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            active_q   <= resetPalette;
            shadow_q   <= resetPalette;
            dirty_q    <= 1'b0;
            pixValid_q <= 1'b0;
            color_q    <= '0;
        end else begin
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            dirty_q    <= dirty_d;
            pixValid_q <= i_pix_valid;
            color_q    <= active_q[i_pix_index];
        end
    end

    assign o_pix_valid = pixValid_q;
    assign o_color     = color_q;
    assign o_dirty     = dirty_q;

endmodule
